// File: rtl/simon_mmio_pkg.sv
// Shared MMIO register map for the peripheral bridge.
// Software headers and RTL take their word addresses from this one place.
package simon_mmio_pkg;

  localparam logic [31:0] MMIO_ADDR_BTN  = 32'd1000;
  localparam logic [31:0] MMIO_ADDR_EVT  = 32'd1001;
  localparam logic [31:0] MMIO_ADDR_RAND = 32'd2000;
  localparam logic [31:0] MMIO_ADDR_LED  = 32'd3000;

  localparam int unsigned RAND_W = 4;

  function automatic logic [31:0] zext4(input logic [3:0] v);
    return {28'd0, v};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser followed by a stable-count debouncer.
// Ports: clock, reset (async low), btn_i raw, stable_o level, rise_o set pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync0_q, sync1_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    accept   = 1'b0;
    if (sync1_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        accept   = 1'b1;
        stable_d = sync1_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync0_q  <= 1'b0;
      sync1_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync0_q  <= btn_i;
      sync1_q  <= sync0_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Rise is flagged on the same edge the stable flop takes the new 1.
  assign stable_o = stable_q;
  assign rise_o   = accept & sync1_q;

endmodule

// File: rtl/mmio_periph_bridge.sv
// MMIO bridge: debounced buttons, W1C event flags, LED register, RNG readback.
// Ports: clock/reset, btn_in, rand_in, CPU mem_* bus, ram_rdata/ram_wren, led.
module mmio_periph_bridge
  import simon_mmio_pkg::*;
#(
  parameter int unsigned NUM_BTN      = 4,
  parameter int unsigned LED_W        = 15,
  parameter int unsigned DEBOUNCE_CYC = 50000,
  parameter logic [31:0] ADDR_BTN     = MMIO_ADDR_BTN,
  parameter logic [31:0] ADDR_EVT     = MMIO_ADDR_EVT,
  parameter logic [31:0] ADDR_RAND    = MMIO_ADDR_RAND,
  parameter logic [31:0] ADDR_LED     = MMIO_ADDR_LED
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic [3:0]         rand_in,
  input  logic [31:0]        mem_addr,
  input  logic               mem_wren,
  input  logic [31:0]        mem_wdata,
  input  logic [31:0]        ram_rdata,
  output logic               ram_wren,
  output logic [31:0]        cpu_rdata,
  output logic [LED_W-1:0]   led
);

  logic [NUM_BTN-1:0] stable, rise;
  logic [NUM_BTN-1:0] evt_q, evt_d, evt_clr;
  logic [LED_W-1:0]   led_q, led_d;
  logic hit_btn, hit_evt, hit_rand, hit_led, hit_any;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .clock   (clock),
      .reset   (reset),
      .btn_i   (btn_in[i]),
      .stable_o(stable[i]),
      .rise_o  (rise[i])
    );
  end

  assign hit_btn  = (mem_addr == ADDR_BTN);
  assign hit_evt  = (mem_addr == ADDR_EVT);
  assign hit_rand = (mem_addr == ADDR_RAND);
  assign hit_led  = (mem_addr == ADDR_LED);
  assign hit_any  = hit_btn | hit_evt | hit_rand | hit_led;

  assign ram_wren = mem_wren & ~hit_any;

  always_comb begin
    evt_clr = '0;
    led_d   = led_q;
    if (mem_wren && hit_evt) evt_clr = mem_wdata[NUM_BTN-1:0];
    if (mem_wren && hit_led) led_d = mem_wdata[LED_W-1:0];
    // Set after clear so a same-cycle rise survives.
    evt_d = (evt_q & ~evt_clr) | rise;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      evt_q <= '0;
      led_q <= '0;
    end else begin
      evt_q <= evt_d;
      led_q <= led_d;
    end
  end

  always_comb begin
    cpu_rdata = ram_rdata;
    unique case (1'b1)
      hit_btn:  cpu_rdata = 32'(stable);
      hit_evt:  cpu_rdata = 32'(evt_q);
      hit_rand: cpu_rdata = zext4(rand_in);
      hit_led:  cpu_rdata = 32'(led_q);
      default:  cpu_rdata = ram_rdata;
    endcase
  end

  assign led = led_q;

  logic unused_wdata;
  assign unused_wdata = ^mem_wdata;

endmodule

// File: tb/tb_mmio_periph_bridge.sv
// Directed bench for mmio_periph_bridge with DEBOUNCE_CYC=4.
// Decode table plus hand sequences for debounce, W1C and reset.
module tb_mmio_periph_bridge;
  import simon_mmio_pkg::*;

  localparam logic [31:0] A_BTN  = 32'd1000;
  localparam logic [31:0] A_EVT  = 32'd1001;
  localparam logic [31:0] A_RAND = 32'd2000;
  localparam logic [31:0] A_LED  = 32'd3000;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  btn_in;
  logic [3:0]  rand_in;
  logic [31:0] mem_addr, mem_wdata, ram_rdata;
  logic        mem_wren;
  logic        ram_wren;
  logic [31:0] cpu_rdata;
  logic [14:0] led;

  int checks = 0;
  int errors = 0;

  mmio_periph_bridge #(
    .NUM_BTN(4), .LED_W(15), .DEBOUNCE_CYC(4)
  ) dut (
    .clock(clock), .reset(reset), .btn_in(btn_in),
    .rand_in(rand_in), .mem_addr(mem_addr),
    .mem_wren(mem_wren), .mem_wdata(mem_wdata),
    .ram_rdata(ram_rdata), .ram_wren(ram_wren),
    .cpu_rdata(cpu_rdata), .led(led)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        wren;
    logic [31:0] ram;
    logic [3:0]  rnd;
    logic        exp_wren;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(string n, logic [31:0] a, logic w,
                              logic [31:0] r, logic [3:0] q,
                              logic ew, logic [31:0] er);
    vec_t v;
    v.name = n; v.addr = a; v.wren = w; v.ram = r;
    v.rnd = q; v.exp_wren = ew; v.exp_rd = er;
    return v;
  endfunction

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic rd(logic [31:0] a);
    mem_addr = a;
    mem_wren = 1'b0;
    #1;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    mem_addr  = a;
    mem_wdata = d;
    mem_wren  = 1'b1;
    tick();
    mem_wren  = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk("rd_btn",   A_BTN,  0, 32'h1111_1111, 4'h3, 0, 32'h0);
    vecs[1]  = mk("rd_evt",   A_EVT,  0, 32'h1111_1111, 4'h3, 0, 32'h0);
    vecs[2]  = mk("rd_rand",  A_RAND, 0, 32'h1111_1111, 4'hA, 0, 32'hA);
    vecs[3]  = mk("rd_led",   A_LED,  0, 32'h1111_1111, 4'h3, 0, 32'h0);
    vecs[4]  = mk("rd_ram4",  32'd4,  0, 32'hDEAD_BEEF, 4'h3, 0, 32'hDEAD_BEEF);
    vecs[5]  = mk("wr_ram4",  32'd4,  1, 32'h1234_5678, 4'h3, 1, 32'h1234_5678);
    vecs[6]  = mk("wr_btn",   A_BTN,  1, 32'h1111_1111, 4'h3, 0, 32'h0);
    vecs[7]  = mk("wr_rand",  A_RAND, 1, 32'h1111_1111, 4'h5, 0, 32'h5);
    vecs[8]  = mk("hi_alias", 32'h8000_03E8, 1, 32'hCAFE_F00D, 4'h3,
                  1, 32'hCAFE_F00D);
    vecs[9]  = mk("near_evt", 32'd1002, 0, 32'h0000_0055, 4'h3, 0, 32'h55);
    vecs[10] = mk("rd_randf", A_RAND, 0, 32'h0, 4'hF, 0, 32'hF);
    vecs[11] = mk("near_led", 32'd3001, 1, 32'h0BAD_0BAD, 4'h3,
                  1, 32'h0BAD_0BAD);

    reset = 1'b0;
    btn_in = '0; rand_in = '0;
    mem_addr = '0; mem_wren = 1'b0;
    mem_wdata = '0; ram_rdata = '0;
    tick(2);
    check("rst_led", 32'(led), 32'h0);
    rd(A_BTN);
    check("rst_btn", cpu_rdata, 32'h0);
    reset = 1'b1;
    mem_addr = 32'd4; mem_wren = 1'b1; #1;
    check("post_rst_wren", 32'(ram_wren), 32'h1);
    mem_wren = 1'b0;

    // Decode table; writes here touch only RAM or read-only regs.
    mem_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 12; i++) begin
      mem_addr  = vecs[i].addr;
      mem_wren  = vecs[i].wren;
      ram_rdata = vecs[i].ram;
      rand_in   = vecs[i].rnd;
      #1;
      check({vecs[i].name, "_wren"}, 32'(ram_wren), 32'(vecs[i].exp_wren));
      check({vecs[i].name, "_rd"}, cpu_rdata, vecs[i].exp_rd);
      tick();
    end
    mem_wren = 1'b0;
    rd(A_LED);
    check("led_untouched", cpu_rdata, 32'h0);
    rd(A_EVT);
    check("evt_untouched", cpu_rdata, 32'h0);

    // Clean press: visible exactly 6 edges later.
    rd(A_BTN);
    btn_in = 4'b0001;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("lat_%0d", i), cpu_rdata, (i == 6) ? 32'h1 : 32'h0);
    end
    rd(A_EVT);
    check("evt_after_press", cpu_rdata, 32'h1);

    // 3-cycle glitch on bit 2 must be ignored.
    btn_in = 4'b0101;
    tick(3);
    btn_in = 4'b0001;
    tick(8);
    rd(A_BTN);
    check("glitch_btn", cpu_rdata, 32'h1);
    rd(A_EVT);
    check("glitch_evt", cpu_rdata, 32'h1);

    // W1C and set-beats-clear.
    btn_in = 4'b0011;
    tick(6);
    check("evt_0011", cpu_rdata, 32'h3);
    wr(A_EVT, 32'h1);
    check("evt_clr0", cpu_rdata, 32'h2);
    btn_in = 4'b0001;
    tick(7);
    check("evt_sticky", cpu_rdata, 32'h2);
    rd(A_BTN);
    check("btn_rel1", cpu_rdata, 32'h1);
    mem_addr = A_EVT;
    btn_in = 4'b0011;
    tick(5);
    wr(A_EVT, 32'h2);
    check("set_wins", cpu_rdata, 32'h2);
    rd(A_BTN);
    check("btn_0011", cpu_rdata, 32'h3);
    wr(A_EVT, 32'hF);
    rd(A_EVT);
    check("evt_clr_all", cpu_rdata, 32'h0);

    // LED load truncates to 15 bits; no RAM write.
    mem_addr = A_LED; mem_wdata = 32'hFFFF_ABCD; mem_wren = 1'b1; #1;
    check("led_wr_wren", 32'(ram_wren), 32'h0);
    tick();
    mem_wren = 1'b0; #1;
    check("led_val", 32'(led), 32'h2BCD);
    check("led_rd", cpu_rdata, 32'h2BCD);

    // Build led=1234, evt=F, counter=2 then reset mid-cycle.
    wr(A_LED, 32'h1234);
    btn_in = 4'h0; tick(7);
    btn_in = 4'hF; tick(7);
    rd(A_EVT);
    check("evt_F", cpu_rdata, 32'hF);
    btn_in = 4'h0; tick(7);
    btn_in = 4'hF; tick(4);
    #2;
    reset = 1'b0;
    #1;
    check("arst_led", 32'(led), 32'h0);
    rd(A_EVT);
    check("arst_evt", cpu_rdata, 32'h0);
    rd(A_LED);
    check("arst_led_rd", cpu_rdata, 32'h0);
    mem_addr = 32'd4; mem_wren = 1'b1; #1;
    check("arst_wren", 32'(ram_wren), 32'h1);
    rd(A_BTN);
    tick(2);
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("rst_lat_%0d", i), cpu_rdata,
            (i == 6) ? 32'hF : 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
